// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// FSM state codes, default widths and the all-ones helper used for the
// divide-by-zero quotient. Optional feature macro: DIV_ZERO_DETECT_EN.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;
  localparam int CNT_W          = $clog2(DEF_DIVIDEND_W);

  // Two-state controller: waiting for work, or iterating one quotient bit per clock
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // All-ones value of the requested width (up to 64 bits), e.g. the saturated quotient
  function automatic logic [63:0] ones(input int width);
    if (width >= 64) begin
      ones = '1;
    end else begin
      ones = (64'd1 << width) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Handshake and data bundle between a requester and the restoring divider.
// The div_zero flag only exists when DIV_ZERO_DETECT_EN is defined.
interface seq_restoring_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic                  div_zero;
`endif

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
`ifdef DIV_ZERO_DETECT_EN
    input  div_zero,
`endif
    input  remainder
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
`ifdef DIV_ZERO_DETECT_EN
    output div_zero,
`endif
    output remainder
  );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor and subtract when it fits.
// Purely combinational; the top reuses a single copy every cycle.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 qbit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W-1:0] diff_low;

  // Shift/compare/subtract. After a real subtraction the remainder is below the
  // divisor, so it always fits DIVISOR_W bits. With a zero divisor the top bit
  // is lost, but the next shift would discard it anyway, so the result matches
  // a DIVISOR_W+1 bit partial remainder exactly.
  always_comb begin
    shifted  = {r_in, next_bit};
    qbit     = (shifted >= {1'b0, divisor});
    diff_low = shifted[DIVISOR_W-1:0] - divisor;
    r_out    = qbit ? diff_low : shifted[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: dividend / divisor, one quotient bit
// per clock, start/busy/done handshake, results held until the next done.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor finishes one cycle after
// accept with a saturated quotient and the div_zero flag raised.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input logic               clk,
  input logic               rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_WIDTH = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIVIDEND_W - 1);

  logic [0:0]            state;
  logic [CNT_WIDTH-1:0]  counter;
  logic [DIVIDEND_W-1:0] dividend_sr;
  logic [DIVIDEND_W-1:0] quot_sr;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W-1:0]  part_rem;
  logic [DIVISOR_W-1:0]  next_rem;
  logic                  qbit;
  logic                  busy_q;
  logic                  done_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
`ifdef DIV_ZERO_DETECT_EN
  localparam logic [DIVIDEND_W-1:0] Q_ONES = DIVIDEND_W'(ones(DIVIDEND_W));
  logic                  zero_pending;
  logic                  div_zero_q;
`endif

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .r_in    (part_rem),
    .next_bit(dividend_sr[DIVIDEND_W-1]),
    .divisor (divisor_q),
    .r_out   (next_rem),
    .qbit    (qbit)
  );

  // Controller, iteration counter, working shift registers and held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter     <= '0;
      dividend_sr <= '0;
      quot_sr     <= '0;
      divisor_q   <= '0;
      part_rem    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
`ifdef DIV_ZERO_DETECT_EN
      zero_pending <= 1'b0;
      div_zero_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= RUN;
            busy_q      <= 1'b1;
            dividend_sr <= bus.dividend;
            divisor_q   <= bus.divisor;
            part_rem    <= '0;
            quot_sr     <= '0;
            counter     <= CNT_LAST;
`ifdef DIV_ZERO_DETECT_EN
            zero_pending <= (bus.divisor == '0);
            div_zero_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef DIV_ZERO_DETECT_EN
          if (zero_pending) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            quot_q       <= Q_ONES;
            rem_q        <= dividend_sr[DIVISOR_W-1:0];
            div_zero_q   <= 1'b1;
            zero_pending <= 1'b0;
          end else begin
`else
          begin
`endif
            part_rem    <= next_rem;
            dividend_sr <= {dividend_sr[DIVIDEND_W-2:0], 1'b0};
            quot_sr     <= {quot_sr[DIVIDEND_W-2:0], qbit};
            counter     <= counter - 1'b1;
            if (counter == '0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              quot_q <= {quot_sr[DIVIDEND_W-2:0], qbit};
              rem_q  <= next_rem;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_zero  = div_zero_q;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (8-bit dividend, 4-bit divisor).
// Stimulus pushes expected results; a negedge monitor pops on every done.
// Works with or without DIV_ZERO_DETECT_EN defined.
module tb_seq_restoring_divider;

  localparam int DW = 8;
  localparam int SW = 4;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dz;
    int            done_cyc;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  logic [DW-1:0] last_q = '0;
  logic [SW-1:0] last_r = '0;
  int            busy_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_restoring_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

  seq_restoring_divider #(
    .DIVIDEND_W(DW),
    .DIVISOR_W (SW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: score every done pulse, and require held results while busy
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q   = '0;
      last_r   = '0;
      busy_cnt = 0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("quotient", 32'(bus.quotient), 32'(e.q));
        check_output("remainder", 32'(bus.remainder), 32'(e.r));
        check_output("done_cycle", 32'(cyc), 32'(e.done_cyc));
        check_output("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        check_output("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
        check_output("div_zero", 32'(bus.div_zero), 32'(e.dz));
`endif
      end
      last_q   = bus.quotient;
      last_r   = bus.remainder;
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
      check_output("hold_quotient", 32'(bus.quotient), 32'(last_q));
      check_output("hold_remainder", 32'(bus.remainder), 32'(last_r));
    end
  end

  // Issue one division; keep leaves start high for back-to-back requests
  task automatic apply_stimulus(input logic [DW-1:0] dvd, input logic [SW-1:0] dvs,
                                input logic [DW-1:0] q, input logic [SW-1:0] r,
                                input bit keep, input bit expect_it);
    exp_t e;
    int   lat;
    logic dz;
    @(negedge clk);
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
    if (bus.busy) begin
      check_output("accept_timeout", 32'(bus.busy), 32'd0);
      return;
    end
`ifdef DIV_ZERO_DETECT_EN
    dz  = (dvs == '0);
    lat = dz ? 1 : DW;
`else
    dz  = 1'b0;
    lat = DW;
`endif
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    check_output("busy_after_accept", 32'(bus.busy), 32'd1);
    if (expect_it) begin
      e.q = q; e.r = r; e.dz = dz; e.done_cyc = cyc + lat; e.lat = lat;
      sb.push_back(e);
    end
    bus.dividend = ~dvd;
    bus.divisor  = ~dvs;
    if (!keep) bus.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] dvd;
    logic [SW-1:0] dvs;
    logic [DW-1:0] eq;
    logic [SW-1:0] er;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_done", 32'(bus.done), 32'd0);
    check_output("reset_quotient", 32'(bus.quotient), 32'd0);
    check_output("reset_remainder", 32'(bus.remainder), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    check_output("reset_div_zero", 32'(bus.div_zero), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);
    apply_stimulus(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 1'b1);
    apply_stimulus(8'd13, 4'd14, 8'd0, 4'd13, 1'b0, 1'b1);
    apply_stimulus(8'd0, 4'd1, 8'd0, 4'd0, 1'b0, 1'b1);
    apply_stimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);

    apply_stimulus(8'd100, 4'd9, 8'd11, 4'd1, 1'b1, 1'b1);
    apply_stimulus(8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 1'b1);

    apply_stimulus(8'd100, 4'd0, 8'hFF, 4'd4, 1'b0, 1'b1);
    apply_stimulus(8'd50, 4'd6, 8'd8, 4'd2, 1'b0, 1'b1);
    apply_stimulus(8'd100, 4'd0, 8'hFF, 4'd4, 1'b0, 1'b1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    apply_stimulus(8'd200, 4'd7, 8'd0, 4'd0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrun_reset_busy", 32'(bus.busy), 32'd0);
    check_output("midrun_reset_done", 32'(bus.done), 32'd0);
    check_output("midrun_reset_quotient", 32'(bus.quotient), 32'd0);
    check_output("midrun_reset_remainder", 32'(bus.remainder), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    check_output("midrun_reset_div_zero", 32'(bus.div_zero), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (DW + 2) @(negedge clk);
    check_output("no_done_after_reset", 32'(bus.done), 32'd0);
    apply_stimulus(8'd50, 4'd6, 8'd8, 4'd2, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      dvd = 8'($urandom_range(0, 255));
      dvs = 4'($urandom_range(0, 15));
      if (dvs != '0) begin
        eq = dvd / {4'd0, dvs};
        er = 4'(dvd % {4'd0, dvs});
      end else begin
        eq = 8'hFF;
        er = dvd[SW-1:0];
      end
      apply_stimulus(dvd, dvs, eq, er, 1'b0, 1'b1);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
